// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: forward selects, FSM states and
// the shadow tag that tracks each in-flight instruction's destination.
package hazard_definitions;

    localparam int HZ_REG_W  = 5;
    localparam int HZ_STAGES = 3;  // EX, MEM, WB

    typedef enum logic [1:0] {
        FWD_M  = 2'b00,
        FWD_W  = 2'b01,
        FWD_RF = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic                valid;
        logic [HZ_REG_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } hz_tag_t;

    function automatic logic tag_hit(hz_tag_t t, logic [HZ_REG_W-1:0] rs);
        tag_hit = t.valid && t.reg_write && (t.rd == rs);
    endfunction

    // x0 and unused sources always read the register file.
    function automatic fwd_sel_t fwd_pick(logic [HZ_REG_W-1:0] rs, logic used,
                                          hz_tag_t ex, hz_tag_t mem);
        if (!used || rs == '0)    fwd_pick = FWD_RF;
        else if (tag_hit(ex, rs))  fwd_pick = FWD_M;
        else if (tag_hit(mem, rs)) fwd_pick = FWD_W;
        else                       fwd_pick = FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_tag_pipe.sv
// Shadow tag shift register EX -> MEM -> WB; frozen when advance is low,
// and a bubble injects an invalid tag into EX.
module hazard_tag_pipe
    import hazard_definitions::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    advance,
    input  logic    bubble,
    input  hz_tag_t id_tag,
    output hz_tag_t ex_tag,
    output hz_tag_t mem_tag,
    output hz_tag_t wb_tag
);

    hz_tag_t [HZ_STAGES-1:0] tags;

    always_ff @(posedge clk) begin
        if (rst) begin
            tags <= '0;
        end else if (advance) begin
            tags[0] <= bubble ? hz_tag_t'('0) : id_tag;
            for (int i = 1; i < HZ_STAGES; i++)
                tags[i] <= tags[i-1];
        end
    end

    assign ex_tag  = tags[0];
    assign mem_tag = tags[1];
    assign wb_tag  = tags[2];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, bubbles, flushes and forward selects.
// Define HAZARD_FWD_EN for forwarding; otherwise every RAW hazard stalls.
module hazard_ctrl
    import hazard_definitions::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [HZ_REG_W-1:0] id_rs1,
    input  logic [HZ_REG_W-1:0] id_rs2,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic [HZ_REG_W-1:0] id_rd,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_valid,
    input  logic                ex_take_branch,
    input  logic                mem_busy,
    output logic                if_stall,
    output logic                id_stall,
    output logic                ex_bubble,
    output logic                id_flush,
    output logic [1:0]          ex_forward_rs1,
    output logic [1:0]          ex_forward_rs2
);

    hz_tag_t   id_tag, ex_tag, mem_tag, wb_tag;
    hz_state_t state, state_nx;
    logic      flush_pending;
    logic      advance;
    logic      hazard;
    fwd_sel_t  sel1, sel2;

    assign id_tag = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
    assign advance = !mem_busy;

    hazard_tag_pipe u_tags (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .bubble  (ex_bubble),
        .id_tag  (id_tag),
        .ex_tag  (ex_tag),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag)
    );

    assign sel1 = fwd_pick(id_rs1, id_uses_rs1, ex_tag, mem_tag);
    assign sel2 = fwd_pick(id_rs2, id_uses_rs2, ex_tag, mem_tag);

`ifdef HAZARD_FWD_EN
    fwd_sel_t fwd1_q, fwd2_q;

    // Only a load still in EX cannot be forwarded in time.
    assign hazard = (id_uses_rs1 && id_rs1 != '0 && ex_tag.valid && ex_tag.mem_read && ex_tag.rd == id_rs1) ||
                    (id_uses_rs2 && id_rs2 != '0 && ex_tag.valid && ex_tag.mem_read && ex_tag.rd == id_rs2);

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd1_q <= FWD_RF;
            fwd2_q <= FWD_RF;
        end else if (advance && !ex_bubble) begin
            fwd1_q <= sel1;
            fwd2_q <= sel2;
        end
    end

    assign ex_forward_rs1 = fwd1_q;
    assign ex_forward_rs2 = fwd2_q;
`else
    assign hazard = (sel1 != FWD_RF) || (sel2 != FWD_RF);

    assign ex_forward_rs1 = FWD_RF;
    assign ex_forward_rs2 = FWD_RF;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HZ_RUN;
            flush_pending <= 1'b0;
        end else begin
            state <= state_nx;
            if (mem_busy && ex_take_branch)
                flush_pending <= 1'b1;
            else if (state == HZ_MEM_WAIT && !mem_busy)
                flush_pending <= 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            HZ_RUN:      if (mem_busy)  state_nx = HZ_MEM_WAIT;
            HZ_MEM_WAIT: if (!mem_busy) state_nx = HZ_RUN;
            default:     state_nx = HZ_RUN;
        endcase
    end

    // A pending flush on MEM_WAIT exit replaces whatever ex_take_branch shows.
    always_comb begin
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_bubble = 1'b0;
        id_flush  = 1'b0;
        if (!rst) begin
            if (mem_busy) begin
                if_stall = 1'b1;
                id_stall = 1'b1;
            end else if ((state == HZ_MEM_WAIT && flush_pending) || ex_take_branch) begin
                id_flush  = 1'b1;
                ex_bubble = 1'b1;
            end else if (hazard) begin
                if_stall  = 1'b1;
                id_stall  = 1'b1;
                ex_bubble = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic,
// all checked against an instruction-level reference model.
module tb_hazard_ctrl;
    import hazard_definitions::*;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, id_valid;
    logic       ex_take_branch, mem_busy;
    logic       if_stall, id_stall, ex_bubble, id_flush;
    logic [1:0] ex_forward_rs1, ex_forward_rs2;

    hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_valid       (id_valid),
        .ex_take_branch (ex_take_branch),
        .mem_busy       (mem_busy),
        .if_stall       (if_stall),
        .id_stall       (id_stall),
        .ex_bubble      (ex_bubble),
        .id_flush       (id_flush),
        .ex_forward_rs1 (ex_forward_rs1),
        .ex_forward_rs2 (ex_forward_rs2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [7:0] got, input int exp);
        checks++;
        if (got !== 8'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the instructions sitting in EX/MEM/WB plus wait/flush flags.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit mr;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;
    bit   m_wait, m_pend;
    int   m_f1 = 2, m_f2 = 2;
    int   o_ifs, o_ids, o_bub, o_fl;

    function automatic bit writes_reg(ins_t s, int rs);
        return s.v && s.wr && s.rd == rs;
    endfunction

    function automatic int fwd_of(int rs, bit used);
        if (!used || rs == 0) return 2;
        if (writes_reg(m_ex, rs)) return 0;
        if (writes_reg(m_mem, rs)) return 1;
        return 2;
    endfunction

    function automatic bit load_in_ex(int rs, bit used);
        return used && rs != 0 && m_ex.v && m_ex.mr && m_ex.rd == rs;
    endfunction

    function automatic bit must_stall();
        if (FWD)
            return load_in_ex(int'(id_rs1), id_uses_rs1) || load_in_ex(int'(id_rs2), id_uses_rs2);
        return fwd_of(int'(id_rs1), id_uses_rs1) != 2 || fwd_of(int'(id_rs2), id_uses_rs2) != 2;
    endfunction

    function automatic ins_t empty_ins();
        ins_t e;
        e.v = 0; e.rd = 0; e.wr = 0; e.mr = 0;
        return e;
    endfunction

    // Inputs are already driven; check the combinational outputs, clock once,
    // advance the model and check the registered forward selects.
    task automatic tick();
        int e_ifs, e_bub, e_fl, n1, n2;
        ins_t nid;
        #1;
        e_ifs = 0; e_bub = 0; e_fl = 0;
        if (!rst) begin
            if (mem_busy) e_ifs = 1;
            else if ((m_wait && m_pend) || ex_take_branch) begin e_fl = 1; e_bub = 1; end
            else if (must_stall()) begin e_ifs = 1; e_bub = 1; end
        end
        o_ifs = int'(if_stall); o_ids = int'(id_stall); o_bub = int'(ex_bubble); o_fl = int'(id_flush);
        chk("if_stall", if_stall, e_ifs);
        chk("id_stall", id_stall, e_ifs);
        chk("ex_bubble", ex_bubble, e_bub);
        chk("id_flush", id_flush, e_fl);
        n1 = fwd_of(int'(id_rs1), id_uses_rs1);
        n2 = fwd_of(int'(id_rs2), id_uses_rs2);
        nid.v = id_valid; nid.rd = int'(id_rd); nid.wr = id_reg_write; nid.mr = id_mem_read;
        @(posedge clk);
        if (rst) begin
            m_ex = empty_ins(); m_mem = empty_ins(); m_wb = empty_ins();
            m_wait = 0; m_pend = 0; m_f1 = 2; m_f2 = 2;
        end else if (mem_busy) begin
            m_wait = 1;
            if (ex_take_branch) m_pend = 1;
        end else begin
            if (FWD && e_bub == 0) begin m_f1 = n1; m_f2 = n2; end
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (e_bub != 0) ? empty_ins() : nid;
            m_wait = 0;
            m_pend = 0;
        end
        #1;
        chk("fwd_rs1", ex_forward_rs1, m_f1);
        chk("fwd_rs2", ex_forward_rs2, m_f2);
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit mb, input bit br,
                         input bit v, input int rd, input bit wr, input bit mr,
                         input int r1, input bit u1, input int r2, input bit u2);
        rst = r; mem_busy = mb; ex_take_branch = br;
        id_valid = v; id_rd = 5'(rd); id_reg_write = wr; id_mem_read = mr;
        id_rs1 = 5'(r1); id_uses_rs1 = u1; id_rs2 = 5'(r2); id_uses_rs2 = u2;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    initial begin
        m_ex = empty_ins(); m_mem = empty_ins(); m_wb = empty_ins();
        m_wait = 0; m_pend = 0;

        drive(1, 1, 1, 1, 3, 1, 1, 3, 1, 3, 1);
        tick();
        chk("rst_quiet", o_ifs | o_fl | o_bub, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst_fwd1", ex_forward_rs1, 2);
        chk("rst_fwd2", ex_forward_rs2, 2);

        // add x5 in EX, ID reads x5
        drive(0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 9, 0, 0, 5, 1, 0, 0); tick();
        chk("add_stall", o_ifs, FWD ? 0 : 1);
        chk("add_fwd", ex_forward_rs1, FWD ? 0 : 2);
        drain();

        // addi x0 in EX, ID reads x0
        drive(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 3, 1, 0, 0, 1, 0, 1); tick();
        chk("x0_stall", o_ifs, 0);
        chk("x0_fwd", ex_forward_rs1, 2);
        drain();

        // lw x7 in EX, ID reads rs2=x7
        drive(0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 4, 1, 0, 0, 0, 7, 1); tick();
        chk("lu_stall", o_ifs, 1);
        chk("lu_bubble", o_bub, 1);
        tick();
        chk("lu_once", o_ifs, FWD ? 0 : 1);
        chk("lu_fwd", ex_forward_rs2, FWD ? 1 : 2);
        drain();

        // taken branch during a load-use hazard
        drive(0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 1, 4, 1, 0, 0, 0, 7, 1); tick();
        chk("br_flush", o_fl, 1);
        chk("br_bubble", o_bub, 1);
        chk("br_nostall", o_ids, 0);
        drain();

        // branch held across a 3-cycle memory wait
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1, 2, 1, 0, 1, 1, 0, 0); tick();
            chk("mw_stall", o_ifs, 1);
            chk("mw_noflush", o_fl, 0);
        end
        drive(0, 0, 1, 1, 2, 1, 0, 1, 1, 0, 0); tick();
        chk("mw_flush4", o_fl, 1);
        chk("mw_nostall4", o_ifs, 0);
        drive(0, 0, 0, 1, 2, 1, 0, 1, 1, 0, 0); tick();
        chk("mw_flush5", o_fl, 0);
        drain();

        // reset while in MEM_WAIT with a flush pending
        drive(0, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("rmw_stall", o_ifs, 0);
        chk("rmw_flush", o_fl, 0);
        drive(0, 0, 0, 1, 2, 1, 0, 6, 1, 6, 1); tick();
        chk("rmw_post_stall", o_ifs, 0);
        chk("rmw_post_flush", o_fl, 0);
        chk("rmw_post_fwd", ex_forward_rs1, 2);

        // random traffic on a small register window to provoke collisions
        for (int n = 0; n < 2000; n++) begin
            bit wr;
            wr = 1'($urandom_range(1));
            drive($urandom_range(99) < 3, $urandom_range(99) < 15, $urandom_range(99) < 10,
                  $urandom_range(9) != 0, $urandom_range(3), wr, wr & 1'($urandom_range(1)),
                  $urandom_range(3), 1'($urandom_range(1)), $urandom_range(3), 1'($urandom_range(1)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-004 SHALL have ports id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads that source.
REQ-005 SHALL have ports id_rd  input  5, id_reg_write  input  1, id_mem_read  input  1  destination info of the ID instruction.
REQ-006 SHALL have port id_valid  input  1  ID holds a real instruction.
REQ-007 SHALL have port ex_take_branch  input  1  taken-branch/jump indication from EX.
REQ-008 SHALL have port mem_busy  input  1  data memory not ready; the pipeline must freeze.
REQ-009 SHALL have ports if_stall, id_stall  output  1 each  hold the PC and the IF/ID register.
REQ-010 SHALL have port ex_bubble  output  1  load a NOP into ID/EX.
REQ-011 SHALL have port id_flush  output  1  clear IF/ID.
REQ-012 SHALL have ports ex_forward_rs1, ex_forward_rs2  output  2 each  registered forward selects for EX.

Function
REQ-013 SHALL use this forward encoding: 2'b00 = M-stage result, 2'b01 = W-stage result, 2'b10 = register file; 2'b11 SHALL never be driven.
REQ-014 SHALL keep internal shadow tags {valid, rd, reg_write, mem_read} for EX, MEM and WB.
- Tags SHALL advance ID->EX->MEM->WB each cycle the pipeline is not frozen.
- A bubbled or flushed slot SHALL enter EX with valid=0.
REQ-015 SHALL compute forward selects in ID and register them into ex_forward_* when ID advances.
- A source matching a valid, writing EX tag SHALL select 2'b00.
- Otherwise, a source matching the MEM tag SHALL select 2'b01.
- Otherwise the source SHALL select 2'b10.
- The EX-tag match SHALL take priority.
REQ-016 SHALL never forward register x0 (rd==0 selects 2'b10); an unused source SHALL select 2'b10.
REQ-017 SHALL treat WB-stage results as visible through the register file (write-through), so no WB-tag forward is needed.
REQ-018 Load-use: when a used ID source matches a valid EX tag with mem_read=1, SHALL assert if_stall=id_stall=ex_bubble=1 for exactly one cycle; on the next cycle that source SHALL select 2'b01.
REQ-019 Branch: when ex_take_branch=1 and mem_busy=0, SHALL assert id_flush=ex_bubble=1 in that cycle, with stalls=0; this SHALL take priority over a load-use stall.
REQ-020 SHALL implement FSM states RUN and MEM_WAIT.
- RUN->MEM_WAIT when mem_busy=1.
- MEM_WAIT->RUN on the first cycle mem_busy=0.
REQ-021 While mem_busy=1, SHALL assert if_stall=id_stall=1, with ex_bubble=0 and id_flush=0.
- Tags and ex_forward_* SHALL hold.
REQ-022 A ex_take_branch seen while mem_busy=1 SHALL set flush_pending.
- The flush SHALL be issued on the MEM_WAIT->RUN cycle, then flush_pending SHALL clear.
- ex_take_branch SHALL be ignored in that cycle (same branch held).
REQ-023 Outputs if_stall, id_stall, ex_bubble and id_flush SHALL be combinational from state, tags and inputs; ex_forward_* SHALL be registered.

Reset
REQ-024 On rst=1 at a clock edge, SHALL apply the reset values below; rst SHALL dominate every other input, including mid-stall and mid-MEM_WAIT.
- All tags invalid.
- State RUN.
- flush_pending=0.
- ex_forward_rs1 = ex_forward_rs2 = 2'b10.
REQ-025 While rst=1, if_stall, id_stall, ex_bubble and id_flush SHALL be 0.

Configuration
REQ-026 With HAZARD_FWD_EN defined, SHALL forward per REQ-015 and REQ-018.
REQ-027 Without HAZARD_FWD_EN:
- ex_forward_* SHALL be constant 2'b10.
- Any used-source match against a valid, writing EX or MEM tag SHALL stall (same outputs as REQ-018) until no match remains.

Structure
REQ-028 Package hazard_definitions SHALL hold:
- fwd_sel_t (FWD_M=2'b00, FWD_W=2'b01, FWD_RF=2'b10);
- hz_state_t (HZ_RUN, HZ_MEM_WAIT);
- the hz_tag_t struct.
REQ-029 The shadow tag shift register SHALL be sub-module hazard_tag_pipe, with advance and bubble inputs.

Verification
REQ-030 Bench SHALL cover: add x5 in EX, ID reads rs1=x5 -> one cycle later ex_forward_rs1=2'b00, no stall.
REQ-031 Bench SHALL cover: lw x7 in EX, ID reads rs2=x7 -> if_stall=id_stall=ex_bubble=1 for 1 cycle, then ex_forward_rs2=2'b01.
REQ-032 Bench SHALL cover: addi x0 in EX, ID reads x0 -> forward 2'b10, no stall.
REQ-033 Bench SHALL cover: ex_take_branch=1 during a load-use hazard -> id_flush=ex_bubble=1, stalls=0.
REQ-034 Bench SHALL cover: ex_take_branch=1 with mem_busy=1 held 3 cycles -> stalls for 3 cycles, id_flush=1 on cycle 4 only.
REQ-035 Bench SHALL cover: rst=1 mid-MEM_WAIT -> next cycle state RUN, all tags invalid, forwards 2'b10, stall outputs 0.
